// File: rtl/vram_arbiter.sv
// Slot-based VRAM arbiter: interleaves two video word fetches per 8-slot cell
// with byte-wide CPU accesses on a single 16-bit VRAM port.
//
// state    | meaning
// ---------|----------------------------------------------------------
// ST_IDLE  | no access this cycle; arbitration on ce_6mp strobes
// ST_VID1  | video word 1 access (ram_cs high, read)
// ST_VID2  | video word 2 access (ram_cs high, read)
// ST_CPU   | CPU access (ram_cs high, read or byte write)
//
// Read data arrives the cycle after ram_cs and is latched at the end of that
// cycle, so vid_dout1/vid_dout2/cpu_dout show new data two cycles after the
// access cycle. cpu_ack pulses in the cycle right after the access cycle.
module vram_arbiter #(
    parameter logic [2:0] CPU_SLOT  = 3'd5,
    parameter logic [2:0] VID_SLOT1 = 3'd0,
    parameter logic [2:0] VID_SLOT2 = 3'd2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_6mp,
    input  logic [2:0]  slot,
    input  logic        fetch,
    input  logic        contend_all,
    input  logic [18:0] vid_addr1,
    input  logic [18:0] vid_addr2,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [18:0] ram_addr,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [1:0]  ram_be,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    output logic [15:0] vid_dout1,
    output logic [15:0] vid_dout2,
    output logic        vid_valid,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_wait
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID1 = 2'd1,
        ST_VID2 = 2'd2,
        ST_CPU  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        cs_d;
    logic        we_d;
    logic [1:0]  be_d;
    logic [18:0] addr_d;
    logic [15:0] din_d;
    logic        cpu_hi_q;
    logic        cpu_hi_d;

    logic        vid_hit1;
    logic        vid_hit2;
    logic        cpu_eligible;
    logic        cpu_grant_ok;

    logic        cap_vid1;
    logic        cap_vid2;
    logic        cap_cpu_rd;
    logic        cell_has_vid1;
    logic        ack_block;

    assign vid_hit1     = fetch && (slot == VID_SLOT1);
    assign vid_hit2     = fetch && (slot == VID_SLOT2);
    assign cpu_eligible = contend_all ? (slot == CPU_SLOT)
                                      : (slot[1:0] == CPU_SLOT[1:0]);
    // cpu_ack is included so the ack cycle itself cannot re-grant before
    // ack_block has been registered.
    assign cpu_grant_ok = cpu_req && cpu_eligible && !vid_hit1 && !vid_hit2
                          && !ack_block && !cpu_ack;

    assign cpu_wait = cpu_req && !cpu_ack && (state_q != ST_CPU);

    // Arbitration: pick the access for the next cycle and prepare its port values.
    always_comb begin
        state_d  = ST_IDLE;
        cs_d     = 1'b0;
        we_d     = 1'b0;
        be_d     = 2'b00;
        addr_d   = ram_addr;
        din_d    = ram_din;
        cpu_hi_d = cpu_hi_q;
        if (state_q == ST_IDLE && ce_6mp) begin
            if (vid_hit1) begin
                state_d = ST_VID1;
                cs_d    = 1'b1;
                be_d    = 2'b11;
                addr_d  = vid_addr1;
            end else if (vid_hit2) begin
                state_d = ST_VID2;
                cs_d    = 1'b1;
                be_d    = 2'b11;
                addr_d  = vid_addr2;
            end else if (cpu_grant_ok) begin
                state_d  = ST_CPU;
                cs_d     = 1'b1;
                we_d     = cpu_we;
                be_d     = cpu_we ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                addr_d   = {1'b0, cpu_addr[18:1]};
                din_d    = {cpu_din, cpu_din};
                cpu_hi_d = cpu_addr[0];
            end
        end
    end

    // State register and registered VRAM port.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_be   <= 2'b00;
            ram_addr <= 19'd0;
            ram_din  <= 16'd0;
            cpu_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ram_cs   <= cs_d;
            ram_we   <= we_d;
            ram_be   <= be_d;
            ram_addr <= addr_d;
            ram_din  <= din_d;
            cpu_hi_q <= cpu_hi_d;
        end
    end

    // Read-data capture pipeline, completion pulses and CPU re-grant blocking.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cap_vid1      <= 1'b0;
            cap_vid2      <= 1'b0;
            cap_cpu_rd    <= 1'b0;
            cpu_ack       <= 1'b0;
            vid_valid     <= 1'b0;
            vid_dout1     <= 16'd0;
            vid_dout2     <= 16'd0;
            cpu_dout      <= 8'd0;
            cell_has_vid1 <= 1'b0;
            ack_block     <= 1'b0;
        end else begin
            cap_vid1   <= (state_q == ST_VID1);
            cap_vid2   <= (state_q == ST_VID2);
            cap_cpu_rd <= (state_q == ST_CPU) && !ram_we;
            cpu_ack    <= (state_q == ST_CPU);
            vid_valid  <= cap_vid2 && cell_has_vid1;
            if (cap_vid1) begin
                vid_dout1 <= ram_dout;
            end
            if (cap_vid2) begin
                vid_dout2 <= ram_dout;
            end
            if (cap_cpu_rd) begin
                cpu_dout <= cpu_hi_q ? ram_dout[15:8] : ram_dout[7:0];
            end
            if (cap_vid1) begin
                cell_has_vid1 <= 1'b1;
            end else if (ce_6mp && slot == 3'd0) begin
                cell_has_vid1 <= 1'b0;
            end
            if (!cpu_req) begin
                ack_block <= 1'b0;
            end else if (cpu_ack) begin
                ack_block <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed vector table, corner-case sequences and
// a randomized run against a schedule-based reference model.
module tb_vram_arbiter;

    localparam int CPU_S = 5;
    localparam int VID_S1 = 0;
    localparam int VID_S2 = 2;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_6mp = 1'b0;
    logic [2:0]  slot = 3'd0;
    logic        fetch = 1'b0;
    logic        contend_all = 1'b0;
    logic [18:0] vid_addr1 = '0;
    logic [18:0] vid_addr2 = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [18:0] ram_addr;
    logic        ram_cs;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [15:0] ram_din;
    logic [15:0] ram_dout = '0;
    logic [15:0] vid_dout1;
    logic [15:0] vid_dout2;
    logic        vid_valid;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        cpu_wait;

    int cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    vram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset), .ce_6mp(ce_6mp), .slot(slot),
        .fetch(fetch), .contend_all(contend_all),
        .vid_addr1(vid_addr1), .vid_addr2(vid_addr2),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .vid_dout1(vid_dout1), .vid_dout2(vid_dout2), .vid_valid(vid_valid),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] mem_word(input logic [18:0] a);
        return a[15:0] * 16'h9E37 + {13'd0, a[18:16]} + 16'h1234;
    endfunction

    // VRAM model: data one cycle after ram_cs, junk otherwise.
    always @(posedge clk_sys) ram_dout <= ram_cs ? mem_word(ram_addr) : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cnt);
        end
    endtask

    // One clk_sys cycle; video counter: one strobe every 4 clocks, slot per strobe.
    task automatic tick();
        @(negedge clk_sys);
        cnt++;
        ce_6mp = (cnt % 4 == 0);
        slot = 3'((cnt / 4) % 8);
    endtask

    task automatic align(input logic [2:0] s);
        do tick(); while (!(ce_6mp && slot == s));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cs"}, ram_cs, 0);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_be"}, ram_be, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_ack"}, cpu_ack, 0);
        chk({tag, "_valid"}, vid_valid, 0);
        chk({tag, "_vd1"}, vid_dout1, 0);
        chk({tag, "_vd2"}, vid_dout2, 0);
        chk({tag, "_cd"}, cpu_dout, 0);
    endtask

    typedef struct {
        logic        ca;
        logic        f;
        logic [2:0]  req_slot;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  din;
        logic [2:0]  exp_slot;
        logic [18:0] exp_addr;
        logic [1:0]  exp_be;
    } vec_t;

    // Reference model: per-cycle schedule of expected events.
    typedef struct {
        logic        cs;
        logic        cpu;
        logic [18:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] din;
        logic        ack;
        logic        valid;
        logic        set_v1;
        logic [15:0] v1;
        logic        set_v2;
        logic [15:0] v2;
        logic        set_cd;
        logic [7:0]  cd;
    } sched_t;

    sched_t      sch[8];
    logic [15:0] m_v1, m_v2;
    logic [7:0]  m_cd;
    logic        m_block;
    int          m_cell, m_v1_cell;
    logic        drv_acked;
    int          drv_hold;

    task automatic model_reset();
        foreach (sch[i]) sch[i] = '{default: 0};
        m_v1 = '0; m_v2 = '0; m_cd = '0; m_block = 0;
        m_cell = 0; m_v1_cell = -1; drv_acked = 0; drv_hold = 0;
    endtask

    task automatic model_step();
        int     i0, i1, i2, i3;
        sched_t e;
        logic   elig;
        logic [15:0] w;
        i0 = cnt % 8; i1 = (cnt + 1) % 8; i2 = (cnt + 2) % 8; i3 = (cnt + 3) % 8;
        e = sch[i0];
        if (e.set_v1) m_v1 = e.v1;
        if (e.set_v2) m_v2 = e.v2;
        if (e.set_cd) m_cd = e.cd;
        chk("r_cs", ram_cs, e.cs);
        if (e.cs) begin
            chk("r_addr", ram_addr, e.addr);
            chk("r_we", ram_we, e.we);
            chk("r_be", ram_be, e.be);
            if (e.we) chk("r_din", ram_din, e.din);
        end else begin
            chk("r_be_idle", ram_be, 0);
            chk("r_we_idle", ram_we, 0);
        end
        chk("r_ack", cpu_ack, e.ack);
        chk("r_valid", vid_valid, e.valid);
        chk("r_vd1", vid_dout1, m_v1);
        chk("r_vd2", vid_dout2, m_v2);
        chk("r_cd", cpu_dout, m_cd);
        chk("r_wait", cpu_wait, cpu_req && !e.ack && !e.cpu);
        if (e.ack) begin
            drv_acked = 1;
            drv_hold = $urandom_range(0, 6);
        end
        if (ce_6mp && slot == 3'd0) m_cell++;
        elig = contend_all ? (int'(slot) == CPU_S) : (int'(slot) % 4 == CPU_S % 4);
        if (!e.cs && ce_6mp) begin
            if (fetch && int'(slot) == VID_S1) begin
                sch[i1].cs = 1; sch[i1].addr = vid_addr1; sch[i1].be = 2'b11;
                sch[i3].set_v1 = 1; sch[i3].v1 = mem_word(vid_addr1);
                m_v1_cell = m_cell;
            end else if (fetch && int'(slot) == VID_S2) begin
                sch[i1].cs = 1; sch[i1].addr = vid_addr2; sch[i1].be = 2'b11;
                sch[i3].set_v2 = 1; sch[i3].v2 = mem_word(vid_addr2);
                sch[i3].valid = (m_v1_cell == m_cell);
            end else if (cpu_req && elig && !m_block) begin
                sch[i1].cs = 1; sch[i1].cpu = 1;
                sch[i1].addr = cpu_addr / 2;
                sch[i1].we = cpu_we;
                sch[i1].be = !cpu_we ? 2'b11 : (cpu_addr % 2 == 1) ? 2'b10 : 2'b01;
                sch[i1].din = {cpu_din, cpu_din};
                sch[i2].ack = 1;
                if (!cpu_we) begin
                    w = mem_word(cpu_addr / 2);
                    sch[i3].set_cd = 1;
                    sch[i3].cd = (cpu_addr % 2 == 1) ? w[15:8] : w[7:0];
                end
                m_block = 1;
            end
        end
        if (!cpu_req) m_block = 0;
        sch[i0] = '{default: 0};
    endtask

    vec_t        vt[7];
    logic        got, p_cs, p_we;
    logic [18:0] p_addr, a1, a2;
    logic [1:0]  p_be;
    logic [15:0] p_din, w16, prev2;
    logic [2:0]  p_slot;
    int          cs_cnt, vv_cnt;

    initial begin
        vt[0] = '{1'b1, 1'b0, 3'd6, 1'b0, 19'h00011, 8'h00, 3'd5, 19'h00008, 2'b11};
        vt[1] = '{1'b0, 1'b1, 3'd0, 1'b1, 19'h00004, 8'hA5, 3'd1, 19'h00002, 2'b01};
        vt[2] = '{1'b0, 1'b0, 3'd2, 1'b0, 19'h7FFFF, 8'h00, 3'd5, 19'h3FFFF, 2'b11};
        vt[3] = '{1'b1, 1'b0, 3'd5, 1'b1, 19'h12345, 8'h3C, 3'd5, 19'h091A2, 2'b10};
        vt[4] = '{1'b0, 1'b0, 3'd1, 1'b0, 19'h40000, 8'h00, 3'd1, 19'h20000, 2'b11};
        vt[5] = '{1'b0, 1'b1, 3'd6, 1'b1, 19'h00101, 8'h5A, 3'd1, 19'h00080, 2'b10};
        vt[6] = '{1'b1, 1'b1, 3'd7, 1'b0, 19'h00020, 8'h00, 3'd5, 19'h00010, 2'b11};

        // Reset state
        reset = 1;
        repeat (3) tick();
        #1 chk_zero("reset");
        chk("reset_din", ram_din, 0);
        tick();
        reset = 0;

        // Vector table: CPU grant slot, port values, ack timing and read byte
        vid_addr1 = 19'h01000; vid_addr2 = 19'h01001;
        for (int i = 0; i < 7; i++) begin
            contend_all = vt[i].ca; fetch = vt[i].f; cpu_req = 0;
            align(vt[i].req_slot);
            cpu_req = 1; cpu_we = vt[i].we; cpu_addr = vt[i].addr; cpu_din = vt[i].din;
            #1 chk("tbl_wait_pending", cpu_wait, 1);
            got = 0;
            for (int k = 0; k < 80 && !got; k++) begin
                p_cs = ram_cs; p_addr = ram_addr; p_we = ram_we; p_be = ram_be;
                p_din = ram_din; p_slot = slot;
                tick();
                #1 if (cpu_ack) got = 1;
            end
            chk("tbl_ack_seen", got, 1);
            chk("tbl_cs", p_cs, 1);
            chk("tbl_slot", p_slot, vt[i].exp_slot);
            chk("tbl_addr", p_addr, vt[i].exp_addr);
            chk("tbl_we", p_we, vt[i].we);
            chk("tbl_be", p_be, vt[i].exp_be);
            if (vt[i].we) chk("tbl_din", p_din, {vt[i].din, vt[i].din});
            chk("tbl_wait_ack", cpu_wait, 0);
            tick();
            #1 chk("tbl_ack_one", cpu_ack, 0);
            if (!vt[i].we) begin
                w16 = mem_word(vt[i].exp_addr);
                chk("tbl_cpu_dout", cpu_dout, vt[i].addr[0] ? w16[15:8] : w16[7:0]);
            end
            cpu_req = 0;
            tick();
        end

        // Video-only cells: accesses at slots 0 and 2, one vid_valid per cell
        contend_all = 1; fetch = 1; cpu_req = 0;
        align(0);
        for (int c = 0; c < 2; c++) begin
            a1 = 19'h10000 + 19'(c * 16); a2 = 19'h23456 + 19'(c * 16);
            vid_addr1 = a1; vid_addr2 = a2;
            cs_cnt = 0; vv_cnt = 0;
            for (int k = 0; k < 32; k++) begin
                #1;
                if (ram_cs) begin
                    cs_cnt++;
                    chk("vid_cs_slot", (slot == 3'd0 || slot == 3'd2), 1);
                    chk("vid_cs_addr", ram_addr, (slot == 3'd0) ? a1 : a2);
                end
                if (vid_valid) vv_cnt++;
                tick();
            end
            chk("vid_cs_count", cs_cnt, 2);
            chk("vid_valid_count", vv_cnt, 1);
            chk("vid_dout1", vid_dout1, mem_word(a1));
            chk("vid_dout2", vid_dout2, mem_word(a2));
        end

        // fetch drops after VID1: no VID2, no vid_valid, vid_dout1 holds new word
        align(0);
        a1 = 19'h2ABCD; vid_addr1 = a1; vid_addr2 = 19'h01234;
        prev2 = vid_dout2;
        cs_cnt = 0; vv_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (ce_6mp && slot == 3'd1) fetch = 0;
            #1;
            if (ram_cs) cs_cnt++;
            if (vid_valid) vv_cnt++;
            tick();
        end
        chk("drop_cs_count", cs_cnt, 1);
        chk("drop_valid_count", vv_cnt, 0);
        chk("drop_vid_dout1", vid_dout1, mem_word(a1));
        chk("drop_vid_dout2", vid_dout2, prev2);

        // Reset during the CPU access cycle, then re-arbitration from IDLE
        fetch = 0; contend_all = 1;
        align(5);
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00022;
        tick();
        #1 chk("rst_grant_cs", ram_cs, 1);
        #1 reset = 1;
        #1 chk_zero("rst_mid");
        tick();
        #1 chk("rst_no_ack", cpu_ack, 0);
        tick();
        reset = 0;
        got = 0;
        for (int k = 0; k < 48 && !got; k++) begin
            #1;
            p_cs = ram_cs; p_slot = slot;
            tick();
            #1 if (cpu_ack) got = 1;
        end
        chk("rst_regrant_ack", got, 1);
        chk("rst_regrant_cs", p_cs, 1);
        chk("rst_regrant_slot", p_slot, 5);
        tick();
        w16 = mem_word(19'h00011);
        #1 chk("rst_regrant_dout", cpu_dout, w16[7:0]);
        cpu_req = 0;
        tick();

        // cpu_req held after ack is not regranted until it drops and rises
        contend_all = 0; fetch = 0;
        align(1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00010;
        cs_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1 if (ram_cs) cs_cnt++;
            tick();
        end
        chk("hold_cs_count", cs_cnt, 1);
        cpu_req = 0;
        tick();
        cpu_req = 1;
        cs_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1 if (ram_cs) cs_cnt++;
            tick();
        end
        chk("rereq_cs_count", cs_cnt, 1);
        cpu_req = 0;

        // Randomized traffic against the reference model
        reset = 1;
        tick(); tick();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = 0;
            if (ce_6mp && slot == 3'd0) begin
                fetch = ($urandom % 4) != 0;
                contend_all = 1'($urandom % 2);
                vid_addr1 = 19'($urandom);
                vid_addr2 = 19'($urandom);
            end else if (ce_6mp && slot == 3'd1 && ($urandom % 6) == 0) begin
                fetch = 0;
            end
            if (cpu_req && drv_acked) begin
                if (drv_hold == 0) begin
                    cpu_req = 0;
                    drv_acked = 0;
                end else begin
                    drv_hold--;
                end
            end else if (!cpu_req && ($urandom % 5) == 0) begin
                cpu_req = 1;
                cpu_we = 1'($urandom % 2);
                cpu_addr = 19'($urandom);
                cpu_din = 8'($urandom);
            end
            #1 model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
